// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: hazard/forwarding controller for the 5-stage RV32 pipeline.
// Covers load-use stall, M/W->E forwarding, branch flush, data-memory wait
// stalls and a counter-driven multi-cycle execute (MC) sequencer.
// Optional perf counters are built only when HAZARD_PERF_CNT_EN is defined;
// otherwise the perf ports are tied to zero.
module hazard_unit_mc #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MC_LATENCY = 34,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [REG_ADDR_W-1:0] i_data_d_rs1,
  input  logic [REG_ADDR_W-1:0] i_data_d_rs2,
  input  logic                  i_ctrl_d_uses_rs1,
  input  logic                  i_ctrl_d_uses_rs2,
  input  logic [REG_ADDR_W-1:0] i_data_e_rs1,
  input  logic [REG_ADDR_W-1:0] i_data_e_rs2,
  input  logic [REG_ADDR_W-1:0] i_data_e_rd,
  input  logic                  i_ctrl_e_is_load,
  input  logic                  i_ctrl_e_mc_op,
  input  logic                  i_ctrl_e_mux_pc_src,
  input  logic [REG_ADDR_W-1:0] i_data_m_rd,
  input  logic [REG_ADDR_W-1:0] i_data_w_rd,
  input  logic                  i_ctrl_m_en_regfile_write,
  input  logic                  i_ctrl_w_en_regfile_write,
  input  logic                  i_ctrl_m_mem_access,
  input  logic                  i_dmem_ready,
  output logic [1:0]            o_data_mux_alu_forward_src_a,
  output logic [1:0]            o_data_mux_alu_forward_src_b,
  output logic                  o_f_stall,
  output logic                  o_d_stall,
  output logic                  o_e_stall,
  output logic                  o_m_stall,
  output logic                  o_w_stall,
  output logic                  o_fd_flush,
  output logic                  o_de_flush,
  output logic                  o_em_flush,
  output logic                  o_mc_start,
  output logic                  o_mc_busy,
  output logic [CNT_W-1:0]      o_perf_load_use_cnt,
  output logic [CNT_W-1:0]      o_perf_mem_wait_cnt,
  output logic [CNT_W-1:0]      o_perf_mc_cnt,
  output logic [CNT_W-1:0]      o_perf_flush_cnt
);

  localparam int unsigned MC_CNT_W = 8;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MC_WAIT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [MC_CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] fwd_a, fwd_b;
  logic       mem_wait;
  logic       load_use_hit;
  logic       lu_stall;
  logic       branch_flush;
  logic       mc_start;
  logic       mc_stall;

  // Forward selects for both E-stage sources; M beats W, x0 never forwards
  always_comb begin
    fwd_a = 2'b00;
    if (i_data_e_rs1 != '0 && i_data_e_rs1 == i_data_m_rd && i_ctrl_m_en_regfile_write)
      fwd_a = 2'b10;
    else if (i_data_e_rs1 != '0 && i_data_e_rs1 == i_data_w_rd && i_ctrl_w_en_regfile_write)
      fwd_a = 2'b01;

    fwd_b = 2'b00;
    if (i_data_e_rs2 != '0 && i_data_e_rs2 == i_data_m_rd && i_ctrl_m_en_regfile_write)
      fwd_b = 2'b10;
    else if (i_data_e_rs2 != '0 && i_data_e_rs2 == i_data_w_rd && i_ctrl_w_en_regfile_write)
      fwd_b = 2'b01;
  end

  // Hazard detection: memory wait freezes everything, branch beats load-use
  always_comb begin
    mem_wait     = i_ctrl_m_mem_access & ~i_dmem_ready;
    load_use_hit = i_ctrl_e_is_load && (i_data_e_rd != '0) &&
                   ((i_data_e_rd == i_data_d_rs1 && i_ctrl_d_uses_rs1) ||
                    (i_data_e_rd == i_data_d_rs2 && i_ctrl_d_uses_rs2));
    branch_flush = i_ctrl_e_mux_pc_src & ~mem_wait;
    lu_stall     = load_use_hit & ~i_ctrl_e_mux_pc_src & ~mem_wait;
  end

  // MC sequencer next-state: start in RUN, count down in MC_WAIT, frozen by mem_wait
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mc_start = 1'b0;
    mc_stall = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (i_ctrl_e_mc_op && !mem_wait) begin
          mc_start = 1'b1;
          mc_stall = 1'b1;
          cnt_d    = MC_CNT_W'(MC_LATENCY - 2);
          state_d  = ST_MC_WAIT;
        end
      end
      ST_MC_WAIT: begin
        if (!mem_wait) begin
          if (cnt_q != '0) begin
            mc_stall = 1'b1;
            cnt_d    = cnt_q - MC_CNT_W'(1);
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // MC sequencer state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output drive; everything reads zero while reset is held
  always_comb begin
    o_data_mux_alu_forward_src_a = fwd_a & {2{i_rst_n}};
    o_data_mux_alu_forward_src_b = fwd_b & {2{i_rst_n}};
    o_f_stall  = i_rst_n & (mem_wait | mc_stall | lu_stall);
    o_d_stall  = i_rst_n & (mem_wait | mc_stall | lu_stall);
    o_e_stall  = i_rst_n & (mem_wait | mc_stall);
    o_m_stall  = i_rst_n & mem_wait;
    o_w_stall  = i_rst_n & mem_wait;
    o_fd_flush = i_rst_n & branch_flush;
    o_de_flush = i_rst_n & (branch_flush | lu_stall);
    o_em_flush = i_rst_n & mc_stall;
    o_mc_start = i_rst_n & mc_start;
    o_mc_busy  = i_rst_n & (state_q == ST_MC_WAIT);
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] perf_lu_q, perf_lu_d;
  logic [CNT_W-1:0] perf_mw_q, perf_mw_d;
  logic [CNT_W-1:0] perf_mc_q, perf_mc_d;
  logic [CNT_W-1:0] perf_fl_q, perf_fl_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && v != '1) ? v + CNT_W'(1) : v;
  endfunction

  // Saturating event counters, one increment per qualifying cycle
  always_comb begin
    perf_lu_d = sat_inc(perf_lu_q, lu_stall);
    perf_mw_d = sat_inc(perf_mw_q, mem_wait);
    perf_mc_d = sat_inc(perf_mc_q, mc_stall);
    perf_fl_d = sat_inc(perf_fl_q, branch_flush);
  end

  // Perf counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      perf_lu_q <= '0;
      perf_mw_q <= '0;
      perf_mc_q <= '0;
      perf_fl_q <= '0;
    end else begin
      perf_lu_q <= perf_lu_d;
      perf_mw_q <= perf_mw_d;
      perf_mc_q <= perf_mc_d;
      perf_fl_q <= perf_fl_d;
    end
  end

  assign o_perf_load_use_cnt = perf_lu_q;
  assign o_perf_mem_wait_cnt = perf_mw_q;
  assign o_perf_mc_cnt       = perf_mc_q;
  assign o_perf_flush_cnt    = perf_fl_q;
`else
  assign o_perf_load_use_cnt = '0;
  assign o_perf_mem_wait_cnt = '0;
  assign o_perf_mc_cnt       = '0;
  assign o_perf_flush_cnt    = '0;
`endif

endmodule
